card_bus_arbiter: RTL

Registered arbiter for the Apple II data-out and IRQ resources shared by the soft slot cards (SuperSerial, SuperSprite, Mockingboard, and later cards). It sits between the card instances and `apple_bus`, in the `clk_logic` domain. Per bus cycle it grants data-out ownership to one card and holds that card's data through a programmable hold window. It also combines the masked card IRQs and counts bus contention events for debug.

---
 rtl/card_bus_pkg.sv | 6 +
 rtl/card_bus_arbiter_if.sv | 27 ++
 rtl/card_prio_enc.sv | 7 +
 rtl/card_bus_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/card_bus_pkg.sv
// Shared types and constants for the slot-card data-out / IRQ arbiter.
package card_bus_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, HOLD} arb_state_t;
  localparam int MAX_CARDS  = 8;
  localparam int COLL_CNT_W = 8;
endpackage

// File: rtl/card_bus_arbiter_if.sv
// Card-side request/data/IRQ bundle plus the arbitrated bus-side results.
interface card_bus_arbiter_if #(parameter int NUM_CARDS = 4);
  logic                          phi1_posedge_i;
  logic [NUM_CARDS-1:0]          rd_en_i;
  logic [NUM_CARDS-1:0][7:0]     data_i;
  logic [NUM_CARDS-1:0]          irq_n_i;
  logic [NUM_CARDS-1:0]          irq_mask_i;
  logic                          clr_stats_i;
  logic                          data_out_en_o;
  logic [7:0]                    data_out_o;
  logic [NUM_CARDS-1:0]          grant_o;
  logic                          irq_n_o;
  logic [NUM_CARDS-1:0]          irq_src_o;
  logic                          collision_o;
  logic [7:0]                    collision_cnt_o;

  modport slave (
    input  phi1_posedge_i, rd_en_i, data_i, irq_n_i, irq_mask_i, clr_stats_i,
    output data_out_en_o, data_out_o, grant_o, irq_n_o, irq_src_o,
           collision_o, collision_cnt_o
  );
  modport master (
    output phi1_posedge_i, rd_en_i, data_i, irq_n_i, irq_mask_i, clr_stats_i,
    input  data_out_en_o, data_out_o, grant_o, irq_n_o, irq_src_o,
           collision_o, collision_cnt_o
  );
endinterface

// File: rtl/card_prio_enc.sv
// Lowest-index one-hot picker: isolates the least significant set bit.
module card_prio_enc #(parameter int W = 4) (
  input  logic [W-1:0] req_i,
  output logic [W-1:0] onehot_o
);
  assign onehot_o = req_i & (~req_i + W'(1));
endmodule

// File: rtl/card_bus_arbiter.sv
// Registered data-out owner arbiter with hold window, IRQ combiner and
// per-bus-cycle contention counter.
module card_bus_arbiter
  import card_bus_pkg::*;
#(
  parameter int NUM_CARDS   = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk_logic,
  input  logic              system_reset_n,
  card_bus_arbiter_if.slave bus
);
  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES);

  arb_state_t                state_q, state_d;
  logic [NUM_CARDS-1:0]      owner_q, owner_d, pick, sel, irq_act, irq_pick, irq_src_q;
  logic [3:0]                hold_q, hold_d;
  logic [7:0]                dout_q, dout_d, mux_data;
  logic [NUM_CARDS-1:0][7:0] mux_terms;
  logic                      en_q, en_d, irq_n_q, irq_n_d;
  logic                      coll_q, coll_d, latch_q, latch_d, coll_evt;
  logic [COLL_CNT_W-1:0]     cnt_q, cnt_d;
  logic                      any_req, multi_req, owner_req, phi1;

  assign phi1      = bus.phi1_posedge_i;
  assign any_req   = |bus.rd_en_i;
  assign multi_req = |(bus.rd_en_i & (bus.rd_en_i - NUM_CARDS'(1)));
  assign owner_req = |(bus.rd_en_i & owner_q);
  assign irq_act   = ~bus.irq_n_i & ~bus.irq_mask_i;

  card_prio_enc #(.W(NUM_CARDS)) u_grant_enc (.req_i(bus.rd_en_i), .onehot_o(pick));
  card_prio_enc #(.W(NUM_CARDS)) u_irq_enc   (.req_i(irq_act),     .onehot_o(irq_pick));

  // In IDLE the mux looks at the card about to be granted so data is valid with grant.
  assign sel = (state_q == IDLE) ? pick : owner_q;
  for (genvar k = 0; k < NUM_CARDS; k++) begin : g_mux
    assign mux_terms[k] = bus.data_i[k] & {8{sel[k]}};
  end
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_CARDS; k++) mux_data = mux_data | mux_terms[k];
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    dout_d  = dout_q;
    if (phi1) begin
      state_d = IDLE;
      owner_d = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          state_d = GRANT;
          owner_d = pick;
          dout_d  = mux_data;
        end
        GRANT: if (owner_req) begin
          dout_d = mux_data;
        end else if (HOLD_CYCLES == 0) begin
          state_d = IDLE;
          owner_d = '0;
        end else begin
          state_d = HOLD;
          hold_d  = HOLD_INIT;
        end
        HOLD: if (owner_req) begin
          state_d = GRANT;
          hold_d  = '0;
          dout_d  = mux_data;
        end else if (hold_q <= 4'd1) begin
          state_d = IDLE;
          owner_d = '0;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - 4'd1;
        end
        default: begin
          state_d = IDLE;
          owner_d = '0;
          hold_d  = '0;
        end
      endcase
    end
    en_d = (state_d != IDLE);
  end

  // One event per bus cycle; the latch still arms when a clear lands on the event.
  always_comb begin
    coll_evt = !phi1 && ((state_q == IDLE) ? multi_req : |(bus.rd_en_i & ~owner_q));
    latch_d  = phi1 ? 1'b0 : (latch_q | coll_evt);
    coll_d   = coll_q;
    cnt_d    = cnt_q;
    if (coll_evt && !latch_q) begin
      coll_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
    if (bus.clr_stats_i) begin
      coll_d = 1'b0;
      cnt_d  = '0;
    end
    irq_n_d = ~|irq_act;
  end

  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      hold_q    <= '0;
      dout_q    <= '0;
      en_q      <= 1'b0;
      irq_n_q   <= 1'b1;
      irq_src_q <= '0;
      coll_q    <= 1'b0;
      latch_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      dout_q    <= dout_d;
      en_q      <= en_d;
      irq_n_q   <= irq_n_d;
      irq_src_q <= irq_pick;
      coll_q    <= coll_d;
      latch_q   <= latch_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.data_out_en_o   = en_q;
  assign bus.data_out_o      = dout_q;
  assign bus.grant_o         = owner_q;
  assign bus.irq_n_o         = irq_n_q;
  assign bus.irq_src_o       = irq_src_q;
  assign bus.collision_o     = coll_q;
  assign bus.collision_cnt_o = cnt_q;
endmodule
